// File: rtl/qos_dequeue_scheduler_pkg.sv
// Shared definitions for the QoS dequeue scheduler: state encoding and default sizing.
package qos_dequeue_scheduler_pkg;

    localparam int QOS_DATA_W     = 64;
    localparam int QOS_WEIGHT_W   = 4;
    localparam int QOS_CNT_W      = 16;
    localparam int QOS_DEF_WEIGHT = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_HI = 2'd1,
        SERVE_LO = 2'd2
    } sched_state_e;

endpackage

// File: rtl/qos_dequeue_scheduler_credit_counter.sv
// Weight register and low-queue service credit for the weighted round-robin scheduler.
module qos_credit_counter
    import qos_dequeue_scheduler_pkg::*;
#(
    parameter int WEIGHT_W   = QOS_WEIGHT_W,
    parameter int DEF_WEIGHT = QOS_DEF_WEIGHT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_weight_wen,
    input  logic [WEIGHT_W-1:0] cfg_weight_in,
    input  logic                reload,
    input  logic                consume,
    output logic                credit_nz,
    output logic                weight_zero
);

    logic [WEIGHT_W-1:0] weight_q, weight_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;

    // A reload always copies the weight held before any same-cycle write.
    always_comb begin
        weight_d = cfg_weight_wen ? cfg_weight_in : weight_q;
        credit_d = credit_q;
        if (reload) begin
            credit_d = weight_q;
        end else if (consume && (credit_q != '0)) begin
            credit_d = credit_q - WEIGHT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight_q <= WEIGHT_W'(DEF_WEIGHT);
            credit_q <= WEIGHT_W'(DEF_WEIGHT);
        end else begin
            weight_q <= weight_d;
            credit_q <= credit_d;
        end
    end

    assign credit_nz   = (credit_q != '0);
    assign weight_zero = (weight_q == '0);

endmodule

// File: rtl/qos_dequeue_scheduler.sv
// Weighted round-robin dequeue of the high/low QoS FIFOs onto one output, whole packets at a time.
module qos_dequeue_scheduler
    import qos_dequeue_scheduler_pkg::*;
#(
    parameter int DATA_W     = QOS_DATA_W,
    parameter int WEIGHT_W   = QOS_WEIGHT_W,
    parameter int DEF_WEIGHT = QOS_DEF_WEIGHT,
    parameter int CNT_W      = QOS_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hi_empty,
    input  logic [DATA_W-1:0]   hi_data,
    input  logic                hi_eop,
    output logic                hi_rd_en,
    input  logic                lo_empty,
    input  logic [DATA_W-1:0]   lo_data,
    input  logic                lo_eop,
    output logic                lo_rd_en,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_eop,
    input  logic                out_rdy,
    input  logic                cfg_weight_wen,
    input  logic [WEIGHT_W-1:0] cfg_weight_in,
    output logic                serving_hi,
    output logic                busy,
    output logic [CNT_W-1:0]    hi_pkt_cnt,
    output logic [CNT_W-1:0]    lo_pkt_cnt
);

    sched_state_e      state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_eop_q, out_eop_d;
    logic              serving_hi_q, serving_hi_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]  lo_cnt_q, lo_cnt_d;

    logic can_load, hi_done, lo_done, idle_reload;
    logic credit_nz, weight_zero;

    qos_credit_counter #(
        .WEIGHT_W   (WEIGHT_W),
        .DEF_WEIGHT (DEF_WEIGHT)
    ) u_credit (
        .clk            (clk),
        .rst            (rst),
        .cfg_weight_wen (cfg_weight_wen),
        .cfg_weight_in  (cfg_weight_in),
        .reload         (idle_reload || lo_done),
        .consume        (hi_done),
        .credit_nz      (credit_nz),
        .weight_zero    (weight_zero)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        can_load = !out_valid_q || out_rdy;
        hi_rd_en = (state_q == SERVE_HI) && !hi_empty && can_load;
        lo_rd_en = (state_q == SERVE_LO) && !lo_empty && can_load;
        hi_done  = hi_rd_en && hi_eop;
        lo_done  = lo_rd_en && lo_eop;

        idle_reload = 1'b0;
        state_d     = state_q;
        unique case (state_q)
            IDLE: begin
                if (!hi_empty && (weight_zero || credit_nz)) begin
                    state_d = SERVE_HI;
                end else if (!lo_empty) begin
                    state_d = SERVE_LO;
                end else if (!hi_empty) begin
                    idle_reload = 1'b1;
                    state_d     = SERVE_HI;
                end
            end
            // A packet is finished only by popping its eop word; an empty FIFO just stalls.
            SERVE_HI: if (hi_done) state_d = IDLE;
            SERVE_LO: if (lo_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_eop_d   = out_eop_q;
        if (hi_rd_en) begin
            out_valid_d = 1'b1;
            out_data_d  = hi_data;
            out_eop_d   = hi_eop;
        end else if (lo_rd_en) begin
            out_valid_d = 1'b1;
            out_data_d  = lo_data;
            out_eop_d   = lo_eop;
        end else if (out_valid_q && out_rdy) begin
            out_valid_d = 1'b0;
        end

        hi_cnt_d     = hi_cnt_q + CNT_W'(hi_done);
        lo_cnt_d     = lo_cnt_q + CNT_W'(lo_done);
        serving_hi_d = (state_d == SERVE_HI);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_eop_q    <= 1'b0;
            serving_hi_q <= 1'b0;
            busy_q       <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_eop_q    <= out_eop_d;
            serving_hi_q <= serving_hi_d;
            busy_q       <= busy_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_eop    = out_eop_q;
    assign serving_hi = serving_hi_q;
    assign busy       = busy_q;
    assign hi_pkt_cnt = hi_cnt_q;
    assign lo_pkt_cnt = lo_cnt_q;

endmodule

// File: tb/tb_qos_dequeue_scheduler.sv
// Self-checking bench: FWFT FIFO models feed the scheduler, a scoreboard checks every output word.
module tb_qos_dequeue_scheduler;

    localparam int DW = 64;
    localparam int WW = 4;
    localparam int CW = 16;

    typedef logic [DW:0] word_t;   // {eop, data}

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hi_empty = 1'b1, lo_empty = 1'b1;
    logic [DW-1:0] hi_data = '0, lo_data = '0;
    logic          hi_eop = 1'b0, lo_eop = 1'b0;
    logic          hi_rd_en, lo_rd_en;
    logic          out_valid, out_eop;
    logic [DW-1:0] out_data;
    logic          out_rdy = 1'b1;
    logic          cfg_weight_wen = 1'b0;
    logic [WW-1:0] cfg_weight_in = '0;
    logic          serving_hi, busy;
    logic [CW-1:0] hi_pkt_cnt, lo_pkt_cnt;

    qos_dequeue_scheduler #(
        .DATA_W(DW), .WEIGHT_W(WW), .DEF_WEIGHT(3), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .hi_empty(hi_empty), .hi_data(hi_data), .hi_eop(hi_eop), .hi_rd_en(hi_rd_en),
        .lo_empty(lo_empty), .lo_data(lo_data), .lo_eop(lo_eop), .lo_rd_en(lo_rd_en),
        .out_valid(out_valid), .out_data(out_data), .out_eop(out_eop), .out_rdy(out_rdy),
        .cfg_weight_wen(cfg_weight_wen), .cfg_weight_in(cfg_weight_in),
        .serving_hi(serving_hi), .busy(busy),
        .hi_pkt_cnt(hi_pkt_cnt), .lo_pkt_cnt(lo_pkt_cnt)
    );

    always #5 clk = ~clk;

    word_t hi_q[$], lo_q[$], exp_q[$];
    int    hs_cyc[$];
    int    cyc = 0;
    int    n_checks = 0, n_errors = 0;
    logic  pend_hi = 1'b0, pend_lo = 1'b0;
    logic  rdy_drive = 1'b1;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: retire last cycle's pops, drive FIFO heads, then sample the DUT mid-cycle.
    task automatic tick();
        word_t e;
        @(negedge clk);
        cyc++;
        if (pend_hi && hi_q.size() > 0) void'(hi_q.pop_front());
        if (pend_lo && lo_q.size() > 0) void'(lo_q.pop_front());
        hi_empty = (hi_q.size() == 0);
        {hi_eop, hi_data} = hi_empty ? word_t'(0) : hi_q[0];
        lo_empty = (lo_q.size() == 0);
        {lo_eop, lo_data} = lo_empty ? word_t'(0) : lo_q[0];
        out_rdy = rdy_drive;
        #1;
        pend_hi = hi_rd_en;
        pend_lo = lo_rd_en;
        if (out_valid && out_rdy) begin
            hs_cyc.push_back(cyc);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("sb_word", 96'({out_eop, out_data}), 96'(e));
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 96'(exp_q.size()), 96'(0));
        repeat (3) tick();
    endtask

    task automatic write_weight(input logic [WW-1:0] w);
        cfg_weight_wen = 1'b1;
        cfg_weight_in  = w;
        tick();
        cfg_weight_wen = 1'b0;
    endtask

    // Load 1-word packets and queue the expected service order given as a string of H/L.
    task automatic load_single(input string order, input int n_hi, input int n_lo, input int base);
        int ih = 0, il = 0;
        for (int i = 0; i < n_hi; i++) hi_q.push_back({1'b1, DW'(base + 'h100 + i)});
        for (int i = 0; i < n_lo; i++) lo_q.push_back({1'b1, DW'(base + 'h200 + i)});
        for (int i = 0; i < order.len(); i++) begin
            if (order[i] == "H") begin
                exp_q.push_back({1'b1, DW'(base + 'h100 + ih)});
                ih++;
            end else begin
                exp_q.push_back({1'b1, DW'(base + 'h200 + il)});
                il++;
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n0, budget;
        logic [DW-1:0] held;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_serving_hi", 96'(serving_hi), 96'(0));
        check("rst_hi_cnt", 96'(hi_pkt_cnt), 96'(0));
        rst = 1'b1;

        // Default weight 3: H,H,H,L pattern with one bubble per packet
        hs_cyc.delete();
        load_single("HHHLHHHLL", 6, 3, 'h1000);
        drain(200);
        check("t1_hs_count", 96'(hs_cyc.size()), 96'(9));
        for (int i = 1; i < hs_cyc.size(); i++) check("t1_bubble", 96'(hs_cyc[i] - hs_cyc[i-1]), 96'(2));
        check("t1_hi_cnt", 96'(hi_pkt_cnt), 96'(6));
        check("t1_lo_cnt", 96'(lo_pkt_cnt), 96'(3));

        // Weight 0: strict priority
        write_weight(4'd0);
        load_single("HHHLL", 3, 2, 'h2000);
        drain(200);
        check("t2_hi_cnt", 96'(hi_pkt_cnt), 96'(9));
        check("t2_lo_cnt", 96'(lo_pkt_cnt), 96'(5));

        // High FIFO runs dry mid-packet: no switch to the waiting low queue
        write_weight(4'd3);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, DW'('h3100 + i)});
        exp_q.push_back({1'b1, DW'('h3200)});
        hi_q.push_back({1'b0, DW'('h3100)});
        hi_q.push_back({1'b0, DW'('h3101)});
        budget = 0;
        while (hi_q.size() != 0 && budget < 50) begin
            tick();
            budget++;
        end
        check("t3_first_words_popped", 96'(hi_q.size()), 96'(0));
        lo_q.push_back({1'b1, DW'('h3200)});
        repeat (5) begin
            tick();
            check("t3_lo_rd_en", 96'(lo_rd_en), 96'(0));
            check("t3_serving_hi", 96'(serving_hi), 96'(1));
        end
        hi_q.push_back({1'b0, DW'('h3102)});
        hi_q.push_back({1'b1, DW'('h3103)});
        drain(100);
        check("t3_hi_cnt", 96'(hi_pkt_cnt), 96'(10));
        check("t3_lo_cnt", 96'(lo_pkt_cnt), 96'(6));

        // Backpressure for 3 cycles mid-packet
        for (int i = 0; i < 4; i++) begin
            hi_q.push_back({(i == 3) ? 1'b1 : 1'b0, DW'('h4100 + i)});
            exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, DW'('h4100 + i)});
        end
        n0 = hs_cyc.size();
        budget = 0;
        while (hs_cyc.size() == n0 && budget < 50) begin
            tick();
            budget++;
        end
        check("t4_started", 96'(hs_cyc.size() - n0), 96'(1));
        rdy_drive = 1'b0;
        tick();
        held = out_data;
        check("t4_hold_valid", 96'(out_valid), 96'(1));
        check("t4_hold_rd_en", 96'(hi_rd_en), 96'(0));
        repeat (2) begin
            tick();
            check("t4_hold_data", 96'(out_data), 96'(held));
            check("t4_hold_rd_en", 96'(hi_rd_en), 96'(0));
        end
        rdy_drive = 1'b1;
        drain(100);
        check("t4_hi_cnt", 96'(hi_pkt_cnt), 96'(11));

        // Weight 1 written while credit is 2
        cfg_weight_wen = 1'b1;
        cfg_weight_in  = 4'd1;
        load_single("HHLHLHLH", 5, 3, 'h5000);
        tick();
        cfg_weight_wen = 1'b0;
        drain(200);
        check("t5_hi_cnt", 96'(hi_pkt_cnt), 96'(16));
        check("t5_lo_cnt", 96'(lo_pkt_cnt), 96'(9));

        // Asynchronous reset mid-packet
        for (int i = 0; i < 4; i++) begin
            hi_q.push_back({(i == 3) ? 1'b1 : 1'b0, DW'('h6100 + i)});
            exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, DW'('h6100 + i)});
        end
        n0 = hs_cyc.size();
        budget = 0;
        while (hs_cyc.size() == n0 && budget < 50) begin
            tick();
            budget++;
        end
        #1 rst = 1'b0;
        #1;
        pend_hi = 1'b0;
        check("t6_out_valid", 96'(out_valid), 96'(0));
        check("t6_out_data", 96'(out_data), 96'(0));
        check("t6_out_eop", 96'(out_eop), 96'(0));
        check("t6_busy", 96'(busy), 96'(0));
        check("t6_serving_hi", 96'(serving_hi), 96'(0));
        check("t6_hi_rd_en", 96'(hi_rd_en), 96'(0));
        check("t6_hi_cnt", 96'(hi_pkt_cnt), 96'(0));
        check("t6_lo_cnt", 96'(lo_pkt_cnt), 96'(0));
        repeat (2) begin
            tick();
            check("t6_rd_en_in_rst", 96'(hi_rd_en), 96'(0));
        end
        rst = 1'b1;
        exp_q.delete();
        foreach (hi_q[i]) exp_q.push_back(hi_q[i]);
        check("t6_remaining_words", 96'(hi_q.size()), 96'(3));
        drain(100);
        check("t6_hi_cnt_after", 96'(hi_pkt_cnt), 96'(1));
        check("t6_lo_cnt_after", 96'(lo_pkt_cnt), 96'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/qos_dequeue_scheduler.md
# qos_dequeue_scheduler

Weighted round-robin dequeue scheduler for the QoS queue stage. It drains the high-priority queue (packets the source-IP matcher flagged) and the low-priority queue onto a single output port. Packets are never interleaved, and a configurable credit guarantees that the low queue gets service. It sits between the two first-word-fall-through (FWFT) packet FIFOs and the downstream output register stage.

## Interface
- `DATA_W`, 64, data word width
- `WEIGHT_W`, 4, width of the credit/weight register
- `DEF_WEIGHT`, 3, high-queue packets served per low-queue packet after reset
- `CNT_W`, 16, width of the per-queue packet counters

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `hi_empty`  in  1  high FIFO empty
- `hi_data`  in  DATA_W  high FIFO head word (FWFT, valid when `!hi_empty`)
- `hi_eop`  in  1  head word is the last word of its packet
- `hi_rd_en`  out  1  pop high FIFO head (combinational)
- `lo_empty`, `lo_data`, `lo_eop`, `lo_rd_en`: same as the high-queue ports, for the low FIFO
- `out_valid`  out  1  output word valid (registered)
- `out_data`  out  DATA_W  output word (registered)
- `out_eop`  out  1  output word is end of packet (registered)
- `out_rdy`  in  1  downstream accepts the word when `out_valid && out_rdy`
- `cfg_weight_wen`  in  1  write the weight register
- `cfg_weight_in`  in  WEIGHT_W  new weight; 0 means strict priority
- `serving_hi`  out  1  current packet is from the high queue
- `busy`  out  1  FSM is not IDLE
- `hi_pkt_cnt`, `lo_pkt_cnt`  out  CNT_W  count of packets completed per queue (eop popped), wrapping

## Operation
- FSM states: IDLE, SERVE_HI, SERVE_LO.
- Decision in IDLE, evaluated in this order:
  1. If weight=0 and `!hi_empty`, go to HI.
  2. Otherwise, if `credit>0` and `!hi_empty`, go to HI.
  3. Otherwise, if `!lo_empty`, go to LO.
  4. Otherwise, if `!hi_empty`, reload `credit=weight` and go to HI.
  5. Otherwise, stay in IDLE.
- Pop rule in SERVE_x: `x_rd_en = !x_empty && (!out_valid || out_rdy)`. Only the served queue is ever popped.
- On a pop, the output register loads data and eop, and `out_valid` is set to 1. When `out_valid && out_rdy` and there is no pop, `out_valid` is cleared to 0.
- Popping the eop word ends the packet:
  - the FSM goes to IDLE;
  - `x_pkt_cnt` increments;
  - in HI, `credit` decrements if it is greater than 0;
  - in LO, `credit` reloads to weight.
- Packet atomicity: if the served FIFO goes empty mid-packet, the FSM stays in SERVE_x and stalls. It never switches queues.
- A weight write updates only the weight register. The new value takes effect at the next credit reload.
- If a weight write and a reload happen in the same cycle, the reload uses the old weight.
- Counters wrap from 2^CNT_W−1 to 0.

## Timing
- Reset (async, `rst=0`) sets:
  - state to IDLE;
  - `out_valid`, `out_data`, `out_eop`, `serving_hi`, `busy` to 0;
  - both counters to 0;
  - weight and `credit` to DEF_WEIGHT.
  - `hi_rd_en` and `lo_rd_en` are 0 while in reset.
- Reset asserted mid-packet abandons the packet. Remaining words stay in the FIFO.
- IDLE with a non-empty queue at cycle t: state is SERVE_x at t+1, and the first pop happens at t+1.
- A word popped at t appears at the outputs at t+1 (`out_valid=1`).
- Throughput is one word per cycle while `out_rdy=1` and the FIFO is not empty.
- Per-packet overhead is exactly one bubble cycle: eop popped at t, IDLE at t+1, next first pop at t+2.
- With `out_rdy=0` and `out_valid=1`: no pop, and the output holds stable.
- `serving_hi` and `busy` are registered and track the state.

## Structure
- A shared qos package holds:
  - the state encoding (IDLE=0, SERVE_HI=1, SERVE_LO=2);
  - DATA_W;
  - DEF_WEIGHT.
- One natural sub-module is `qos_credit_counter`. It holds the weight register, the credit register, and the reload/decrement logic, and exposes `credit_nz`.

## Test plan
- **Weight 3, both queues full of 1-word packets, `out_rdy=1`:** output order is H,H,H,L,H,H,H,L. Exactly one bubble between packets.
- **Weight 0, both queues non-empty:** only high packets are output until `hi_empty`. Then low packets follow, and `lo_pkt_cnt` increments.
- **4-word high packet; high FIFO goes empty after word 2 for 5 cycles while the low queue is non-empty:** `lo_rd_en` stays 0. Words 3–4 follow with no interleave, and `out_eop` is high only on word 4.
- **`out_rdy` low for 3 cycles mid-packet:** `out_data` is stable, `hi_rd_en=0`, and there is no word loss or duplication. Checked against a scoreboard.
- **`cfg_weight_in=1` written mid high-burst with credit=2:** two more high packets, then L. After that the pattern is H,L,H,L.
- **`rst` driven low mid-packet:** all outputs are 0 immediately (async). After release, the FSM restarts from IDLE and the counters read 0.
